// File: rtl/packet_rx.sv
// Fixed-length frame receiver behind a byte UART: optional sync header, BYTES payload bytes,
// one checksum byte (XOR or additive), inter-byte timeout and error reporting.
module packet_rx #(
    parameter int unsigned BYTES     = 4,
    parameter bit          SYNC_EN   = 1'b1,
    parameter logic [7:0]  SYNC_BYTE = 8'hA5,
    parameter bit          CSUM_MODE = 1'b0,
    parameter int unsigned TIMEOUT   = 1000
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [7:0]         rx_data,
    input  logic               rx_valid,
    output logic [BYTES*8-1:0] packet_data,
    output logic               packet_valid,
    output logic               packet_error,
    output logic               err_kind,
    output logic               busy,
    output logic [7:0]         err_count
);

    localparam int unsigned IW = (BYTES > 1) ? $clog2(BYTES) : 1;
    localparam int unsigned CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(BYTES - 1);
    localparam logic [CW-1:0] TO_LAST  = CW'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

    typedef enum logic [1:0] {StHunt, StPayload, StCheck} state_t;

    state_t             state;
    logic [IW-1:0]      idx;
    logic [7:0]         acc;
    logic [CW-1:0]      idle_cnt;
    logic [BYTES*8-1:0] shadow;

    function automatic state_t rst_state();
        if (SYNC_EN) return StHunt;
        return StPayload;
    endfunction

    function automatic logic [7:0] fold(input logic [7:0] a, input logic [7:0] b);
        if (CSUM_MODE) return a + b;
        return a ^ b;
    endfunction

    // busy doubles as "frame started": it gates the idle timer, so an unstarted
    // PAYLOAD (no header mode) never times out.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= rst_state();
            idx          <= '0;
            acc          <= '0;
            idle_cnt     <= '0;
            shadow       <= '0;
            packet_data  <= '0;
            packet_valid <= 1'b0;
            packet_error <= 1'b0;
            err_kind     <= 1'b0;
            busy         <= 1'b0;
            err_count    <= '0;
        end else begin
            packet_valid <= 1'b0;
            packet_error <= 1'b0;
            if (rx_valid) begin
                idle_cnt <= '0;
                unique case (state)
                    StHunt: begin
                        if (rx_data == SYNC_BYTE) begin
                            state <= StPayload;
                            idx   <= '0;
                            acc   <= '0;
                            busy  <= 1'b1;
                        end
                    end
                    StPayload: begin
                        shadow[(BYTES - 1 - int'(idx)) * 8 +: 8] <= rx_data;
                        acc  <= fold(acc, rx_data);
                        busy <= 1'b1;
                        if (idx == LAST_IDX) state <= StCheck;
                        else idx <= idx + IW'(1);
                    end
                    default: begin
                        if (fold(acc, rx_data) == 8'h00) begin
                            packet_data  <= shadow;
                            packet_valid <= 1'b1;
                        end else begin
                            packet_error <= 1'b1;
                            err_kind     <= 1'b0;
                            if (err_count != 8'hFF) err_count <= err_count + 8'd1;
                        end
                        state <= rst_state();
                        idx   <= '0;
                        acc   <= '0;
                        busy  <= 1'b0;
                    end
                endcase
            end else if (TIMEOUT != 0 && busy) begin
                if (idle_cnt == TO_LAST) begin
                    packet_error <= 1'b1;
                    err_kind     <= 1'b1;
                    if (err_count != 8'hFF) err_count <= err_count + 8'd1;
                    state    <= rst_state();
                    idx      <= '0;
                    acc      <= '0;
                    idle_cnt <= '0;
                    busy     <= 1'b0;
                end else begin
                    idle_cnt <= idle_cnt + CW'(1);
                end
            end
        end
    end

endmodule
